systolic_mac_sequencer: RTL and testbench
=========================================

// Module: systolic_mac_sequencer
// PURPOSE
//  Sequences one ROWS x COLS systolic array of MAC processing elements for a single matmul tile.
//  - Accepts a job command and clears all PE accumulators.
//  - Streams K operand vectors from the A/B operand buffers, with a per-row/col skew enable.
//  - Waits for the wavefront to drain, then hands results out one array row per handshake.
//  Sits between the layer controller (command side) and the PE array / operand buffers.
// PARAMETERS
//  ROWS   4    PE rows (A operands enter row-wise)
//  COLS   4    PE columns (B operands enter column-wise)
//  K_MAX  256  max reduction length per job
//  KW     $clog2(K_MAX+1)  width of K count/address (derived, not overridden)
//  RW     $clog2(ROWS)>0 ? $clog2(ROWS) : 1  row index width (derived)
// PORTS
//  clk          in   1     clock
//  rst_n        in   1     reset, synchronous, active-low
//  cmd_valid    in   1     job request
//  cmd_ready    out  1     high only in IDLE
//  cmd_k        in   KW    reduction length; 0 allowed; >K_MAX saturates to K_MAX
//  pe_clr       out  1     1-cycle synchronous accumulator clear to every PE
//  op_rd_en     out  1     operand buffer read strobe; data appears at the array 1 cycle later
//  op_rd_addr   out  KW    k index of the current read, 0..k-1
//  row_en       out  ROWS  skewed A-feed enable; bit r = feed strobe delayed r+1 cycles
//  col_en       out  COLS  skewed B-feed enable; bit c = feed strobe delayed c+1 cycles
//  res_valid    out  1     result row available
//  res_ready    in   1     consumer accepts row
//  res_row      out  RW    array row muxed onto the result bus
//  busy         out  1     high in every state except IDLE
//  done         out  1     1-cycle pulse after the last result beat is accepted
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, all counters 0, skew lines 0.
//   - All outputs 0 except cmd_ready=1. Applies mid-job: the job is dropped and no done pulse is issued.
//  IDLE: cmd_ready=1. On cmd_valid: latch k=min(cmd_k,K_MAX), go to CLEAR.
//  CLEAR (1 cycle): pe_clr=1. Go to FEED if k>0, else to DRAIN.
//  FEED (k cycles): op_rd_en=1, op_rd_addr=0..k-1 incrementing each cycle.
//   - Leaves on the cycle where op_rd_addr==k-1.
//  DRAIN: counter covers the skew pipeline plus wavefront, D = max(ROWS,COLS) + ROWS + COLS - 1 cycles.
//   - During DRAIN, row_en/col_en continue shifting out residual ones; no new feeds are issued.
//   - Counter expiry -> READOUT, with res_row=0.
//  READOUT: res_valid=1. res_row and res_valid are held stable while res_ready=0.
//   - On res_valid&&res_ready: res_row++.
//   - On the beat with res_row==ROWS-1: done=1 next cycle, state -> IDLE.
//  Skew: two shift registers fed by op_rd_en, giving row_en[r] = op_rd_en delayed r+1 and col_en[c] = op_rd_en delayed c+1.
//   - Each array edge input is therefore gated exactly k cycles.
//  Widths:
//   - op_rd_addr counter is KW bits, so K_MAX-1 never wraps.
//   - Drain counter is $clog2(D+1) bits.
//   - No arithmetic on data: the sequencer never touches operands or accumulators.
//  Boundaries:
//   - cmd_valid while busy is ignored (cmd_ready=0); the request must be held by the sender.
//   - k=0 produces a clear then readout of zero accumulators.
//   - k=K_MAX feeds addresses 0..K_MAX-1.
//   - res_ready held high gives ROWS back-to-back beats.
//   - done and the next cmd_ready rise in the same cycle; a new job may be accepted that cycle.
// STRUCTURE
//  Shared package nn_accel_pkg:
//   - seq_state_t enum {IDLE, CLEAR, FEED, DRAIN, READOUT}
//   - localparam function for drain length D
//  Sub-module mac_skew_line #(N): N-tap shift register, in -> out[N-1:0].
//   - Instantiated twice (ROWS, COLS).
//  FSM, k/addr counter, drain counter and readout counter live in the top.
// TESTING
//  1. ROWS=COLS=4, cmd_k=8:
//     - pe_clr 1 cycle after accept; op_rd_en high 8 cycles, addr 0..7.
//     - row_en[3] high 8 cycles starting 4 cycles after the first op_rd_en.
//     - 4 result beats with res_row 0..3, then done.
//  2. cmd_k=0: clear, no op_rd_en, DRAIN of D=11 cycles, 4 beats, done.
//  3. Backpressure: res_ready toggles 1,0,0,1 per cycle.
//     - res_row holds while ready=0; exactly 4 beats; done follows the beat with res_row=3.
//  4. cmd_k=300 with K_MAX=256: exactly 256 reads, last op_rd_addr=255.
//  5. cmd_valid held across a running job: cmd_ready=0 until the done cycle.
//     - The second job is accepted on the done cycle; its pe_clr follows 1 cycle later.
//  6. rst_n low for 1 cycle mid-FEED at addr 3:
//     - All outputs at reset values next cycle; no done pulse; skew lines cleared.
//     - The next job runs normally.

Source files
------------

// File: rtl/nn_accel_pkg.sv
// Shared types and helpers for the NN accelerator sequencing blocks.
// Holds the systolic sequencer state encoding and the drain-length calculation.
package nn_accel_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        FEED    = 3'd2,
        DRAIN   = 3'd3,
        READOUT = 3'd4
    } seq_state_t;

    // Skew pipeline depth plus wavefront traversal of the array.
    function automatic int drain_len(input int rows, input int cols);
        return ((rows > cols) ? rows : cols) + rows + cols - 1;
    endfunction

endpackage

// File: rtl/mac_skew_line.sv
// N-tap shift register producing the skewed feed enables for one array edge.
// Tap i carries the input delayed by i+1 cycles.
module mac_skew_line #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_in,
    output logic [N-1:0] o_out
);

    logic [N-1:0] r_taps;

    // Shift the feed strobe one tap per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_taps <= {N{1'b0}};
        end else begin
            r_taps[0] <= i_in;
            for (int i = 1; i < N; i++) begin
                r_taps[i] <= r_taps[i-1];
            end
        end
    end

    assign o_out = r_taps;

endmodule

// File: rtl/systolic_mac_sequencer.sv
// Sequences one systolic MAC tile: clear, stream K operand vectors with skew,
// drain the wavefront, then hand out one result row per handshake.
module systolic_mac_sequencer
    import nn_accel_pkg::*;
#(
    parameter  int ROWS  = 4,
    parameter  int COLS  = 4,
    parameter  int K_MAX = 256,
    localparam int KW    = $clog2(K_MAX + 1),
    localparam int RW    = ($clog2(ROWS) > 0) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic [KW-1:0]   i_cmd_k,
    output logic            o_pe_clr,
    output logic            o_op_rd_en,
    output logic [KW-1:0]   o_op_rd_addr,
    output logic [ROWS-1:0] o_row_en,
    output logic [COLS-1:0] o_col_en,
    output logic            o_res_valid,
    input  logic            i_res_ready,
    output logic [RW-1:0]   o_res_row,
    output logic            o_busy,
    output logic            o_done
);

    localparam int D   = drain_len(ROWS, COLS);
    localparam int DCW = $clog2(D + 1);

    seq_state_t r_state;
    seq_state_t w_next;

    logic [KW-1:0]  r_k;
    logic [KW-1:0]  r_addr;
    logic [DCW-1:0] r_drain;
    logic [RW-1:0]  r_row;

    logic [KW-1:0]  w_k_sat;
    logic [KW-1:0]  w_addr_nxt;
    logic [DCW-1:0] w_drain_nxt;
    logic [RW-1:0]  w_row_nxt;
    logic           w_accept;
    logic           w_beat;
    logic           w_last_beat;

    logic r_cmd_ready;
    logic r_busy;
    logic r_pe_clr;
    logic r_op_rd_en;
    logic r_res_valid;
    logic r_done;

    logic [ROWS-1:0] w_row_en;
    logic [COLS-1:0] w_col_en;

    // Next-state, handshake decode and counter next values
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_beat      = 1'b0;
        w_last_beat = 1'b0;
        w_k_sat     = i_cmd_k;
        w_addr_nxt  = {KW{1'b0}};
        w_drain_nxt = {DCW{1'b0}};
        w_row_nxt   = {RW{1'b0}};

        if (i_cmd_k > KW'(K_MAX)) begin
            w_k_sat = KW'(K_MAX);
        end else begin
            w_k_sat = i_cmd_k;
        end

        case (r_state)
            IDLE: begin
                if (i_cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = CLEAR;
                end else begin
                    w_next   = IDLE;
                end
            end
            CLEAR: begin
                if (r_k == {KW{1'b0}}) begin
                    w_next = DRAIN;
                end else begin
                    w_next = FEED;
                end
            end
            FEED: begin
                if (r_addr == r_k - KW'(1)) begin
                    w_next = DRAIN;
                end else begin
                    w_next     = FEED;
                    w_addr_nxt = r_addr + KW'(1);
                end
            end
            DRAIN: begin
                if (r_drain == DCW'(D - 1)) begin
                    w_next = READOUT;
                end else begin
                    w_next      = DRAIN;
                    w_drain_nxt = r_drain + DCW'(1);
                end
            end
            READOUT: begin
                w_beat = i_res_ready;
                if (i_res_ready && (r_row == RW'(ROWS - 1))) begin
                    w_last_beat = 1'b1;
                    w_next      = IDLE;
                end else if (i_res_ready) begin
                    w_next    = READOUT;
                    w_row_nxt = r_row + RW'(1);
                end else begin
                    // Backpressure: hold the row index until the consumer accepts
                    w_next    = READOUT;
                    w_row_nxt = r_row;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs (outputs follow the next state)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_k         <= {KW{1'b0}};
            r_addr      <= {KW{1'b0}};
            r_drain     <= {DCW{1'b0}};
            r_row       <= {RW{1'b0}};
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_pe_clr    <= 1'b0;
            r_op_rd_en  <= 1'b0;
            r_res_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_k         <= w_accept ? w_k_sat : r_k;
            r_addr      <= w_addr_nxt;
            r_drain     <= w_drain_nxt;
            r_row       <= w_row_nxt;
            r_cmd_ready <= (w_next == IDLE);
            r_busy      <= (w_next != IDLE);
            r_pe_clr    <= (w_next == CLEAR);
            r_op_rd_en  <= (w_next == FEED);
            r_res_valid <= (w_next == READOUT);
            r_done      <= w_last_beat && w_beat;
        end
    end

    mac_skew_line #(.N(ROWS)) u_row_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .i_in  (r_op_rd_en),
        .o_out (w_row_en)
    );

    mac_skew_line #(.N(COLS)) u_col_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .i_in  (r_op_rd_en),
        .o_out (w_col_en)
    );

    assign o_cmd_ready  = r_cmd_ready;
    assign o_busy       = r_busy;
    assign o_pe_clr     = r_pe_clr;
    assign o_op_rd_en   = r_op_rd_en;
    assign o_op_rd_addr = r_addr;
    assign o_row_en     = w_row_en;
    assign o_col_en     = w_col_en;
    assign o_res_valid  = r_res_valid;
    assign o_res_row    = r_row;
    assign o_done       = r_done;

endmodule

// File: tb/tb_systolic_mac_sequencer.sv
// Directed bench for systolic_mac_sequencer (ROWS=COLS=4, K_MAX=256, drain 11 cycles).
// Cycle 0 is the cycle cmd_valid is presented; outputs are sampled 1 time unit after each edge.
module tb_systolic_mac_sequencer;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int K_MAX = 256;
    localparam int KW    = 9;
    localparam int RW    = 2;

    logic            clk;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [KW-1:0]   cmd_k;
    logic            pe_clr;
    logic            op_rd_en;
    logic [KW-1:0]   op_rd_addr;
    logic [ROWS-1:0] row_en;
    logic [COLS-1:0] col_en;
    logic            res_valid;
    logic            res_ready;
    logic [RW-1:0]   res_row;
    logic            busy;
    logic            done;

    int n_checks;
    int n_errors;

    typedef struct {
        int clr_n, clr_first;
        int rd_n, rd_first, rd_last_addr, addr_err;
        int row0_first, row3_n, row3_first, col3_n;
        int valid_first, beats, row_err, hold_err;
        int done_n, done_cyc, rdy_in_job;
        int rdy_at_done, busy_at_done;
    } job_stats_t;

    systolic_mac_sequencer #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_k      (cmd_k),
        .o_pe_clr     (pe_clr),
        .o_op_rd_en   (op_rd_en),
        .o_op_rd_addr (op_rd_addr),
        .o_row_en     (row_en),
        .o_col_en     (col_en),
        .o_res_valid  (res_valid),
        .i_res_ready  (res_ready),
        .o_res_row    (res_row),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one job and records what the DUT does, cycle by cycle, until done or a budget.
    // bp=1 applies the 1,0,0,1 ready pattern from the first READOUT cycle; hold keeps cmd_valid up.
    task automatic run_job(input int k, input bit bp, input bit hold, output job_stats_t s);
        int cyc;
        int ro_idx;
        bit prev_stall;
        bit rdy;
        logic [RW-1:0] prev_row;
        logic [3:0] pat;
        pat = 4'b1001;
        s = '{default: 0};
        s.clr_first = -1; s.rd_first = -1; s.rd_last_addr = -1; s.row0_first = -1;
        s.row3_first = -1; s.valid_first = -1; s.done_cyc = -1;
        cyc = 0; ro_idx = 0; prev_stall = 1'b0; prev_row = '0;
        cmd_k = KW'(k);
        cmd_valid = 1'b1;
        res_ready = 1'b0;
        while (s.done_n == 0 && cyc < 2000) begin
            step();
            cyc++;
            if (!hold) cmd_valid = 1'b0;
            if (pe_clr) begin s.clr_n++; if (s.clr_first < 0) s.clr_first = cyc; end
            if (op_rd_en) begin
                if (op_rd_addr !== KW'(s.rd_n)) s.addr_err++;
                if (s.rd_first < 0) s.rd_first = cyc;
                s.rd_last_addr = int'(op_rd_addr);
                s.rd_n++;
            end
            if (row_en[0] && s.row0_first < 0) s.row0_first = cyc;
            if (row_en[3]) begin s.row3_n++; if (s.row3_first < 0) s.row3_first = cyc; end
            if (col_en[3]) s.col3_n++;
            if (done) begin
                s.done_n++; s.done_cyc = cyc;
                s.rdy_at_done = int'(cmd_ready); s.busy_at_done = int'(busy);
            end else if (cmd_ready) begin
                s.rdy_in_job++;
            end
            if (res_valid) begin
                if (s.valid_first < 0) s.valid_first = cyc;
                if (prev_stall && res_row !== prev_row) s.hold_err++;
                rdy = bp ? pat[ro_idx % 4] : 1'b1;
                ro_idx++;
                res_ready = rdy;
                if (rdy) begin
                    if (res_row !== RW'(s.beats)) s.row_err++;
                    s.beats++;
                end
                prev_stall = !rdy;
                prev_row = res_row;
            end else begin
                if (prev_stall) s.hold_err++;
                prev_stall = 1'b0;
                res_ready = 1'b0;
            end
        end
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_k = '0; res_ready = 1'b0;
        step(); step();
        n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_checks++; if ({pe_clr, op_rd_en, res_valid, done} !== 4'b0000) begin n_errors++; $display("FAIL reset_strobes: got %b want 0000", {pe_clr, op_rd_en, res_valid, done}); end
        n_checks++; if (op_rd_addr !== 9'd0 || res_row !== 2'd0) begin n_errors++; $display("FAIL reset_counters: got addr=%0d row=%0d want 0,0", op_rd_addr, res_row); end
        n_checks++; if ({row_en, col_en} !== 8'h00) begin n_errors++; $display("FAIL reset_skew: got %h want 00", {row_en, col_en}); end
        rst_n = 1'b1;
        step();
        n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL reset_idle_after: got ready=%0b busy=%0b want 1,0", cmd_ready, busy); end
    endtask

    task automatic test_k8();
        job_stats_t s;
        run_job(8, 1'b0, 1'b0, s);
        n_checks++; if (s.clr_n != 1 || s.clr_first != 1) begin n_errors++; $display("FAIL k8_pe_clr: got n=%0d at %0d want 1 at 1", s.clr_n, s.clr_first); end
        n_checks++; if (s.rd_n != 8 || s.rd_first != 2) begin n_errors++; $display("FAIL k8_reads: got n=%0d from %0d want 8 from 2", s.rd_n, s.rd_first); end
        n_checks++; if (s.addr_err != 0 || s.rd_last_addr != 7) begin n_errors++; $display("FAIL k8_addr: got errs=%0d last=%0d want 0,7", s.addr_err, s.rd_last_addr); end
        n_checks++; if (s.row0_first != 3) begin n_errors++; $display("FAIL k8_row_en0: got first=%0d want 3", s.row0_first); end
        n_checks++; if (s.row3_n != 8 || s.row3_first != 6) begin n_errors++; $display("FAIL k8_row_en3: got n=%0d from %0d want 8 from 6", s.row3_n, s.row3_first); end
        n_checks++; if (s.col3_n != 8) begin n_errors++; $display("FAIL k8_col_en3: got n=%0d want 8", s.col3_n); end
        n_checks++; if (s.valid_first != 21) begin n_errors++; $display("FAIL k8_first_valid: got %0d want 21", s.valid_first); end
        n_checks++; if (s.beats != 4 || s.row_err != 0) begin n_errors++; $display("FAIL k8_beats: got beats=%0d row_errs=%0d want 4,0", s.beats, s.row_err); end
        n_checks++; if (s.done_cyc != 25) begin n_errors++; $display("FAIL k8_done_cycle: got %0d want 25", s.done_cyc); end
        n_checks++; if (s.rdy_in_job != 0 || s.rdy_at_done != 1 || s.busy_at_done != 0) begin n_errors++; $display("FAIL k8_ready_busy: got rdy_in_job=%0d rdy@done=%0d busy@done=%0d want 0,1,0", s.rdy_in_job, s.rdy_at_done, s.busy_at_done); end
        step();
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL k8_done_pulse_width: got %0b want 0", done); end
    endtask

    task automatic test_k0();
        job_stats_t s;
        run_job(0, 1'b0, 1'b0, s);
        n_checks++; if (s.clr_n != 1 || s.rd_n != 0 || s.row3_n != 0) begin n_errors++; $display("FAIL k0_no_feed: got clr=%0d rd=%0d row3=%0d want 1,0,0", s.clr_n, s.rd_n, s.row3_n); end
        n_checks++; if (s.valid_first != 13) begin n_errors++; $display("FAIL k0_drain_len: got first valid %0d want 13", s.valid_first); end
        n_checks++; if (s.beats != 4 || s.row_err != 0 || s.done_cyc != 17) begin n_errors++; $display("FAIL k0_readout: got beats=%0d errs=%0d done@%0d want 4,0,17", s.beats, s.row_err, s.done_cyc); end
    endtask

    task automatic test_backpressure();
        job_stats_t s;
        run_job(2, 1'b1, 1'b0, s);
        n_checks++; if (s.valid_first != 15) begin n_errors++; $display("FAIL bp_first_valid: got %0d want 15", s.valid_first); end
        n_checks++; if (s.hold_err != 0) begin n_errors++; $display("FAIL bp_hold: got %0d hold violations want 0", s.hold_err); end
        n_checks++; if (s.beats != 4 || s.row_err != 0) begin n_errors++; $display("FAIL bp_beats: got beats=%0d errs=%0d want 4,0", s.beats, s.row_err); end
        n_checks++; if (s.done_cyc != 23) begin n_errors++; $display("FAIL bp_done_cycle: got %0d want 23", s.done_cyc); end
    endtask

    task automatic test_k_saturate();
        job_stats_t s;
        run_job(300, 1'b0, 1'b0, s);
        n_checks++; if (s.rd_n != 256 || s.addr_err != 0) begin n_errors++; $display("FAIL ksat_reads: got n=%0d errs=%0d want 256,0", s.rd_n, s.addr_err); end
        n_checks++; if (s.rd_last_addr != 255) begin n_errors++; $display("FAIL ksat_last_addr: got %0d want 255", s.rd_last_addr); end
        n_checks++; if (s.row3_n != 256 || s.done_cyc != 273) begin n_errors++; $display("FAIL ksat_timing: got row3=%0d done@%0d want 256,273", s.row3_n, s.done_cyc); end
    endtask

    task automatic test_back_to_back();
        job_stats_t s;
        int rd;
        int steps;
        bit seen_done;
        run_job(3, 1'b0, 1'b1, s);
        n_checks++; if (s.rdy_in_job != 0 || s.done_n != 1 || s.rdy_at_done != 1) begin n_errors++; $display("FAIL b2b_first_job: got rdy_in_job=%0d done=%0d rdy@done=%0d want 0,1,1", s.rdy_in_job, s.done_n, s.rdy_at_done); end
        step();
        cmd_valid = 1'b0;
        n_checks++; if (pe_clr !== 1'b1 || cmd_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_second_accept: got pe_clr=%0b ready=%0b want 1,0", pe_clr, cmd_ready); end
        rd = 0; steps = 0; seen_done = 1'b0;
        res_ready = 1'b1;
        while (!seen_done && steps < 200) begin
            step();
            steps++;
            if (op_rd_en) rd++;
            if (done) seen_done = 1'b1;
        end
        res_ready = 1'b0;
        n_checks++; if (!seen_done || steps != 19 || rd != 3) begin n_errors++; $display("FAIL b2b_second_job: got done=%0b after %0d steps rd=%0d want 1,19,3", seen_done, steps, rd); end
    endtask

    task automatic test_reset_mid_feed();
        job_stats_t s;
        int steps;
        int n_done;
        int n_skew;
        bit found;
        cmd_k = 9'd8; cmd_valid = 1'b1; res_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        found = 1'b0; steps = 0;
        while (!found && steps < 50) begin
            step();
            steps++;
            if (op_rd_en && op_rd_addr == 9'd3) found = 1'b1;
        end
        n_checks++; if (!found || steps != 4) begin n_errors++; $display("FAIL rst_reach_addr3: got found=%0b steps=%0d want 1,4", found, steps); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL rst_mid_ready_busy: got %0b,%0b want 1,0", cmd_ready, busy); end
        n_checks++; if ({pe_clr, op_rd_en, res_valid, done} !== 4'b0000 || op_rd_addr !== 9'd0) begin n_errors++; $display("FAIL rst_mid_outputs: got strobes=%b addr=%0d want 0000,0", {pe_clr, op_rd_en, res_valid, done}, op_rd_addr); end
        n_checks++; if ({row_en, col_en} !== 8'h00) begin n_errors++; $display("FAIL rst_mid_skew: got %h want 00", {row_en, col_en}); end
        n_done = 0; n_skew = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) n_done++;
            if ({row_en, col_en, op_rd_en, res_valid} != 10'd0) n_skew++;
        end
        res_ready = 1'b0;
        n_checks++; if (n_done != 0 || n_skew != 0) begin n_errors++; $display("FAIL rst_mid_quiet: got done=%0d active=%0d want 0,0", n_done, n_skew); end
        run_job(3, 1'b0, 1'b0, s);
        n_checks++; if (s.rd_n != 3 || s.beats != 4 || s.row_err != 0 || s.done_cyc != 20) begin n_errors++; $display("FAIL rst_next_job: got rd=%0d beats=%0d errs=%0d done@%0d want 3,4,0,20", s.rd_n, s.beats, s.row_err, s.done_cyc); end
    endtask

    initial begin
        clk = 1'b0;
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_k8();
        test_k0();
        test_backpressure();
        test_k_saturate();
        test_back_to_back();
        test_reset_mid_feed();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
